serial_adder: RTL
=================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand and sum width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: start  input  1  request to add; sampled only in IDLE.
REQ-005 Port: a  input  WIDTH  operand A, captured on the accepting edge.
REQ-006 Port: b  input  WIDTH  operand B, captured on the accepting edge.
REQ-007 Port: cin  input  1  carry-in, captured on the accepting edge.
REQ-008 Port: busy  output  1  high while an addition is in progress (RUN state).
REQ-009 Port: done  output  1  one-cycle pulse; sum/cout final in that cycle.
REQ-010 Port: sum  output  WIDTH  result register; holds last result until the next accept.
REQ-011 Port: cout  output  1  final carry-out; holds until the next accept.

Function
REQ-012 FSM states SHALL be IDLE, RUN and DONE.
REQ-013 IDLE with start=1 at an edge SHALL:
- load a, b into shift registers;
- load cin into the carry flop;
- clear the bit counter and sum;
- enter RUN.
REQ-014 Each RUN edge SHALL compute one bit LSB-first with a full adder built from two half adders: s=a0^b0^c, c'=(a0&b0)|(c&(a0^b0)).
REQ-015 Each RUN edge SHALL shift both operand registers right by one, shift s into sum MSB, update carry to c' and increment the counter.
REQ-016 Exactly WIDTH RUN edges SHALL occur; the WIDTH-th edge SHALL enter DONE with sum = (a+b+cin) mod 2^WIDTH and cout = bit WIDTH of a+b+cin.
REQ-017 Latency: done SHALL be high in the cycle following the WIDTH-th edge after the accepting edge, and SHALL last exactly one cycle.
REQ-018 DONE SHALL return to IDLE on the next edge unconditionally.
REQ-019 start SHALL be ignored in RUN and DONE; there is no queuing.
REQ-020 A start in the first IDLE cycle after DONE SHALL be accepted; back-to-back throughput is one result per WIDTH+2 cycles.
REQ-021 sum and cout SHALL NOT be valid while busy=1 and SHALL be used only when done=1 or in a later IDLE cycle.
REQ-022 Changes on a, b or cin after the accepting edge SHALL NOT affect the result.
REQ-023 The bit counter SHALL be $clog2(WIDTH+1) bits wide and SHALL NOT wrap within one operation.

Reset
REQ-024 rst=1 at an edge SHALL force IDLE, with busy=0, done=0, sum=0, cout=0, carry=0, counter=0 and operand registers=0.
REQ-025 rst takes priority over start and over every state transition.
REQ-026 rst asserted mid-RUN SHALL abort the operation with no done pulse.
REQ-027 start SHALL NOT be accepted on any edge where rst=1.

Structure
REQ-028 Package serial_adder_pkg SHALL hold:
- the state enumeration (IDLE, RUN, DONE);
- default constant WIDTH_DEFAULT=8.
REQ-029 One sub-module, full_adder_cell (a, b, cin -> s, cout, combinational, built from two half-adder instances), SHALL implement the per-bit arithmetic.
REQ-030 The FSM, counter, shift registers and carry flop SHALL reside in serial_adder.

Verification (WIDTH=8)
REQ-031 Basic add: a=3, b=5, cin=0, start pulsed -> busy high 8 cycles; done in 9th cycle after accept; sum=8'd8, cout=0.
REQ-032 Wrap-around: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Max carry: a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
REQ-033 Start while busy: second start with a=1, b=1 pulsed 3 cycles after the first accept -> ignored; first result unchanged; exactly one done pulse.
REQ-034 Mid-op reset: rst asserted in RUN cycle 4 -> next cycle IDLE, all outputs 0, no done pulse; a following start yields a correct result.
REQ-035 Back-to-back: 100+27 then start in the first IDLE cycle after done with 200+100, cin=1:
- results 8'd127/cout 0, then 8'd45/cout 1;
- done pulses 10 cycles apart.
REQ-036 Operand stability: a, b and cin randomised every cycle during RUN -> result matches values captured at accept.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

    localparam int WIDTH_DEFAULT = 8;

    // IDLE: waiting for start; RUN: one result bit per edge; DONE: one-cycle result strobe.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder_cell.sv
// One-bit full adder built from two half adders.
// The first half adder combines the operand bits (propagate p, generate g1).
// The second folds in the carry. The carry-out is g1 | (cin & p).
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;
    logic g1;
    logic g2;

    half_adder u_ha_ab (
        .a (a),
        .b (b),
        .s (p),
        .c (g1)
    );

    half_adder u_ha_pc (
        .a (p),
        .b (cin),
        .s (s),
        .c (g2)
    );

    assign cout = g1 | g2;

endmodule

// File: rtl/half_adder.sv
// One-bit half adder: sum and carry of two bits.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder. Operands are captured on the accepting edge.
// The adder then consumes one bit per RUN edge, LSB first, and shifts each
// result bit into the top of the sum register. After WIDTH RUN edges the FSM
// enters DONE for one cycle. It then returns to IDLE.
//
// Handshake: start is sampled only in IDLE (and never while rst=1). busy marks
// the RUN cycles. done is a one-cycle strobe, and sum/cout are valid in that
// cycle and hold through the following IDLE cycles until the next accept.
// There is no backpressure and no queuing of requests.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output state_t           dbg_state_o
);

    // Wide enough to count 0..WIDTH; the count never wraps within one operation.
    localparam int              CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]   ONE  = CW'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             fa_s;
    logic             fa_c;

    full_adder_cell u_fa (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_c)
    );

    // State and datapath registers; reset clears everything and wins over all transitions.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and datapath updates; every register holds unless the current state changes it.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                sum_d   = {fa_s, sum_q[WIDTH-1:1]};
                carry_d = fa_c;
                cnt_d   = cnt_q + ONE;
                if (cnt_q == LAST) begin
                    cout_d  = fa_c;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign sum         = sum_q;
    assign cout        = cout_q;
    assign dbg_state_o = state_q;

endmodule
